// File: rtl/inst_buf_pkg.sv
// inst_buf_pkg: instruction buffer entry type and default sizes.
`include "cpu_config.svh"
`ifndef INST_BUF_ADDR
`define INST_BUF_ADDR 32
`endif
`ifndef INST_BUF_INST
`define INST_BUF_INST 32
`endif
package inst_buf_pkg;
    localparam int ADDR_W    = `INST_BUF_ADDR;
    localparam int INST_W    = `INST_BUF_INST;
    localparam int FETCH_W   = `FetchWidth;
    localparam int DECODE_W  = `DecodeWidth;
    localparam int BUF_DEPTH = `InstBufDepth;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              pred;
    } InstBufEnt_t;
endpackage

// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch-side push / decode-side pop bundle; master drives pushes, takes and flush.
interface inst_buffer_if
    import inst_buf_pkg::*;
#(
    parameter int ADDR      = ADDR_W,
    parameter int INST      = INST_W,
    parameter int IN_WIDTH  = FETCH_W,
    parameter int OUT_WIDTH = DECODE_W,
    parameter int DEPTH     = BUF_DEPTH
);
    logic                                 flush;
    logic [IN_WIDTH-1:0]                  in_valid;
    logic [IN_WIDTH*ADDR-1:0]             in_pc;
    logic [IN_WIDTH*INST-1:0]             in_inst;
    logic [IN_WIDTH-1:0]                  in_pred;
    logic                                 in_ready;
    logic [OUT_WIDTH-1:0]                 out_valid;
    logic [OUT_WIDTH*ADDR-1:0]            out_pc;
    logic [OUT_WIDTH*INST-1:0]            out_inst;
    logic [OUT_WIDTH-1:0]                 out_pred;
    logic [$clog2(OUT_WIDTH+1)-1:0]       out_take;
    logic [$clog2(DEPTH+1)-1:0]           count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_pred, out_take,
        input  in_ready, out_valid, out_pc, out_inst, out_pred, count
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_pred, out_take,
        output in_ready, out_valid, out_pc, out_inst, out_pred, count
    );
endinterface

// File: rtl/cpu_config.svh
// cpu_config: front-end sizing defaults shared by the instruction buffer and its neighbours.
`ifndef CPU_CONFIG_SVH
`define CPU_CONFIG_SVH
`define InstBufDepth 8
`define FetchWidth 2
`define DecodeWidth 2
`endif

// File: rtl/inst_buf_ptr.sv
// inst_buf_ptr: modulo-DEPTH pointer advancing by a variable step; clr or reset returns it to 0.
module inst_buf_ptr #(
    parameter int DEPTH = 8,
    parameter int SW    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [SW-1:0]            step,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;

    // DEPTH is a power of two, so natural overflow gives the wrap
    always_comb ptr_d = clr ? '0 : ptr_q + PW'(step);

    always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;

    assign ptr = ptr_q;
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: fetch-to-decode circular buffer, IN_WIDTH pushed / OUT_WIDTH popped per cycle.
// Define INST_BUF_BYPASS_EN to forward input slots straight to the outputs while empty.
module inst_buffer
    import inst_buf_pkg::*;
#(
    parameter int ADDR      = ADDR_W,
    parameter int INST      = INST_W,
    parameter int IN_WIDTH  = FETCH_W,
    parameter int OUT_WIDTH = DECODE_W,
    parameter int DEPTH     = BUF_DEPTH
) (
    input logic          clk,
    input logic          reset,
    inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int MW = IN_WIDTH > OUT_WIDTH ? IN_WIDTH : OUT_WIDTH;
    localparam int MI = MW > 1 ? $clog2(MW) : 1;
    localparam int SW = $clog2(MW + 1);

    InstBufEnt_t   ent_q [DEPTH];
    InstBufEnt_t   ent_d [DEPTH];
    InstBufEnt_t   in_ent [MW];
    logic [MW-1:0] in_v;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head, tail;
    logic [SW-1:0] head_step, tail_step;
    logic          byp, push;
    int            skip, n_wr;

`ifdef INST_BUF_BYPASS_EN
    assign byp = count_q == '0 && !bus.flush;
`else
    assign byp = 1'b0;
`endif
    assign bus.in_ready = DEPTH - int'(count_q) >= IN_WIDTH;
    assign bus.count    = count_q;
    assign push         = bus.in_ready && bus.in_valid[0];

    always_comb begin
        in_v = '0;
        for (int i = 0; i < MW; i++) in_ent[i] = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            in_v[i]   = bus.in_valid[i];
            in_ent[i] = '{pc: bus.in_pc[i*ADDR +: ADDR], inst: bus.in_inst[i*INST +: INST], pred: bus.in_pred[i]};
        end
    end

    // While bypassing, the first out_take input slots go straight to decode and are never stored
    always_comb begin
        skip      = byp ? int'(bus.out_take) : 0;
        n_wr      = push && $countones(bus.in_valid) > skip ? $countones(bus.in_valid) - skip : 0;
        tail_step = SW'(n_wr);
        head_step = byp ? '0 : SW'(bus.out_take);
        count_d   = bus.flush ? '0 : CW'(int'(count_q) + n_wr - int'(head_step));
        ent_d     = ent_q;
        for (int j = 0; j < IN_WIDTH; j++)
            if (!bus.flush && j < n_wr) ent_d[tail + PW'(j)] = in_ent[MI'(skip + j)];
    end

    always_comb begin
        bus.out_valid = '0;
        bus.out_pc    = '0;
        bus.out_inst  = '0;
        bus.out_pred  = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            bus.out_valid[i]           = byp ? in_v[i] && bus.in_ready : int'(count_q) > i;
            bus.out_pc[i*ADDR +: ADDR] = byp ? in_ent[i].pc : ent_q[head + PW'(i)].pc;
            bus.out_inst[i*INST +: INST] = byp ? in_ent[i].inst : ent_q[head + PW'(i)].inst;
            bus.out_pred[i]            = byp ? in_ent[i].pred : ent_q[head + PW'(i)].pred;
        end
    end

    always_ff @(posedge clk) count_q <= reset ? '0 : count_d;

    always_ff @(posedge clk) ent_q <= ent_d;

    inst_buf_ptr #(.DEPTH(DEPTH), .SW(SW)) u_head (
        .clk(clk), .reset(reset), .clr(bus.flush), .step(head_step), .ptr(head)
    );

    inst_buf_ptr #(.DEPTH(DEPTH), .SW(SW)) u_tail (
        .clk(clk), .reset(reset), .clr(bus.flush), .step(tail_step), .ptr(tail)
    );
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed checks of inst_buffer at DEPTH=8, IN_WIDTH=OUT_WIDTH=2.
// Bypass expectations follow INST_BUF_BYPASS_EN.
module tb_inst_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    inst_buffer_if #(.ADDR(32), .INST(32), .IN_WIDTH(2), .OUT_WIDTH(2), .DEPTH(8)) bus ();

    inst_buffer #(.ADDR(32), .INST(32), .IN_WIDTH(2), .OUT_WIDTH(2), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] take);
        bus.in_valid = v;
        bus.in_pc    = {p1, p0};
        bus.in_inst  = {~p1, ~p0};
        bus.in_pred  = {p1[2], p0[2]};
        bus.out_take = take;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus legality: thermometer in_valid and no over-take
    always @(negedge clk) if (!reset) begin
        n_chk++;
        assert ((bus.in_valid & (bus.in_valid + 2'd1)) == 2'b00 && int'(bus.out_take) <= $countones(bus.out_valid)) else begin
            n_fail++;
            $error("FAIL protocol: in_valid %b out_take %0d out_valid %b", bus.in_valid, bus.out_take, bus.out_valid);
        end
    end

    initial begin
        bus.flush = 1'b0;
        drive(2'b00, 0, 0, 0);
        tick;
        tick;
        reset = 1'b0;
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 1);

        drive(2'b11, 32'h100, 32'h104, 0);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("push_count", 64'(bus.count), 2);
        chk("push_valid", 64'(bus.out_valid), 2'b11);
        chk("push_pc0", 64'(bus.out_pc[31:0]), 32'h100);
        chk("push_pc1", 64'(bus.out_pc[63:32]), 32'h104);
        chk("push_inst0", 64'(bus.out_inst[31:0]), 32'hffff_feff);
        chk("push_pred", 64'(bus.out_pred), 2'b10);

        for (int k = 1; k < 4; k++) begin
            drive(2'b11, 32'h100 + 8 * k, 32'h104 + 8 * k, 0);
            chk("fill_ready", 64'(bus.in_ready), 1);
            tick;
        end
        drive(2'b00, 0, 0, 0);
        chk("full_count", 64'(bus.count), 8);
        chk("full_ready", 64'(bus.in_ready), 0);
        drive(2'b11, 32'h900, 32'h904, 0);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("full_ignored", 64'(bus.count), 8);

        for (int k = 0; k < 4; k++) begin
            chk("drain_pc0", 64'(bus.out_pc[31:0]), 64'(32'h100 + 8 * k));
            chk("drain_pc1", 64'(bus.out_pc[63:32]), 64'(32'h104 + 8 * k));
            drive(2'b00, 0, 0, 2);
            tick;
            drive(2'b00, 0, 0, 0);
            chk("drain_count", 64'(bus.count), 64'(8 - 2 * (k + 1)));
            chk("drain_ready", 64'(bus.in_ready), 1);
        end
        chk("empty_valid", 64'(bus.out_valid), 0);

        drive(2'b11, 32'h100, 32'h104, 0);
        tick;
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 32'h108 + 8 * k, 32'h10c + 8 * k, 2);
            chk("steady_pc0", 64'(bus.out_pc[31:0]), 64'(32'h100 + 8 * k));
            chk("steady_pc1", 64'(bus.out_pc[63:32]), 64'(32'h104 + 8 * k));
            tick;
            chk("steady_count", 64'(bus.count), 2);
        end
        drive(2'b00, 0, 0, 0);

        drive(2'b01, 32'h158, 0, 0);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("part_pre_count", 64'(bus.count), 3);
        drive(2'b01, 32'h200, 0, 1);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("part_count", 64'(bus.count), 3);
        chk("part_pc0", 64'(bus.out_pc[31:0]), 32'h154);
        chk("part_pc1", 64'(bus.out_pc[63:32]), 32'h158);
        drive(2'b00, 0, 0, 2);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("part_slot2_count", 64'(bus.count), 1);
        chk("part_slot2_pc", 64'(bus.out_pc[31:0]), 32'h200);
        chk("part_slot2_valid", 64'(bus.out_valid), 2'b01);

        drive(2'b11, 32'h210, 32'h214, 0);
        tick;
        drive(2'b11, 32'h218, 32'h21c, 0);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("pre_flush_count", 64'(bus.count), 5);
        bus.flush = 1'b1;
        drive(2'b11, 32'h400, 32'h404, 0);
        tick;
        bus.flush = 1'b0;
        drive(2'b00, 0, 0, 0);
        chk("flush_count", 64'(bus.count), 0);
        chk("flush_valid", 64'(bus.out_valid), 0);
        chk("flush_ready", 64'(bus.in_ready), 1);
        drive(2'b11, 32'h500, 32'h504, 0);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("post_flush_count", 64'(bus.count), 2);
        chk("post_flush_pc0", 64'(bus.out_pc[31:0]), 32'h500);
        chk("post_flush_pc1", 64'(bus.out_pc[63:32]), 32'h504);

        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_count", 64'(bus.count), 0);
        chk("mid_rst_valid", 64'(bus.out_valid), 0);

`ifdef INST_BUF_BYPASS_EN
        drive(2'b11, 32'h300, 32'h304, 1);
        #1;
        chk("byp_valid", 64'(bus.out_valid), 2'b11);
        chk("byp_pc0", 64'(bus.out_pc[31:0]), 32'h300);
        chk("byp_pc1", 64'(bus.out_pc[63:32]), 32'h304);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("byp_count", 64'(bus.count), 1);
        chk("byp_next_pc0", 64'(bus.out_pc[31:0]), 32'h304);
        chk("byp_next_valid", 64'(bus.out_valid), 2'b01);
`else
        drive(2'b11, 32'h300, 32'h304, 0);
        #1;
        chk("nobyp_valid", 64'(bus.out_valid), 0);
        tick;
        drive(2'b00, 0, 0, 0);
        chk("nobyp_count", 64'(bus.count), 2);
        chk("nobyp_pc0", 64'(bus.out_pc[31:0]), 32'h300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Parametrised decoupling buffer between instruction fetch and decode. It generalises the single-instruction fetch→decode hand-off to IN_WIDTH instructions pushed and OUT_WIDTH instructions popped per cycle. It holds up to DEPTH entries in a circular buffer and supports a same-cycle flush on redirect. Each entry is a {pc, inst, pred} tuple; it sits inside the front end, ahead of the decoder.

## Interface
- ADDR, 32, PC width
- INST, 32, instruction width
- IN_WIDTH, 2, max instructions pushed per cycle (≥1)
- OUT_WIDTH, 2, max instructions presented and popped per cycle (≥1)
- DEPTH, 8, entries; power of two, ≥ IN_WIDTH + OUT_WIDTH
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- flush  in  1  active-high; discard all contents
- in_valid  in  IN_WIDTH  per-slot valid; thermometer (slot i valid ⇒ slots <i valid)
- in_pc  in  IN_WIDTH*ADDR  slot i at bits [i*ADDR +: ADDR]
- in_inst  in  IN_WIDTH*INST  packed like in_pc
- in_pred  in  IN_WIDTH  predicted-taken bit per slot
- in_ready  out  1  high when free entries ≥ IN_WIDTH
- out_valid  out  OUT_WIDTH  thermometer; slot i holds the i-th oldest entry
- out_pc  out  OUT_WIDTH*ADDR  packed like in_pc
- out_inst  out  OUT_WIDTH*INST  packed like in_pc
- out_pred  out  OUT_WIDTH  predicted-taken bit per slot
- out_take  in  $clog2(OUT_WIDTH+1)  entries consumed this cycle; must be ≤ popcount(out_valid)
- count  out  $clog2(DEPTH+1)  registered occupancy

## Operation
- State: head, tail (log2 DEPTH bits, wrap modulo DEPTH), count, and DEPTH entry registers.
- Push fires when in_ready && in_valid[0]. It writes popcount(in_valid) entries at tail, tail+1, … and advances tail by that amount.
- Pop advances head by out_take.
- Next count is count + pushed − out_take. Simultaneous push and pop is legal.
- in_ready = (DEPTH − count) ≥ IN_WIDTH. It uses registered count only; same-cycle pops do not raise it.
- out_valid[i] = (count > i). out_* slot i reads entry (head+i) mod DEPTH. Outputs are combinational from registers.
- A non-thermometer in_valid, or out_take > popcount(out_valid), is illegal. The verification bench asserts on both. The RTL behaviour for these inputs is undefined.
- Flush: next head = tail = count = 0. This takes priority over push and pop in the same cycle; the input in that cycle is dropped.
- Reset: same effect as flush. Entry data is not cleared.
- Reset values: count=0, out_valid=0, in_ready=1 (guaranteed by the DEPTH ≥ IN_WIDTH constraint). out_pc, out_inst and out_pred are don't-care while their out_valid bit is 0.

## Timing
- Base latency: an entry pushed in cycle t is visible on out_* in cycle t+1.
- Throughput: min(IN_WIDTH, OUT_WIDTH) instructions per cycle sustained, with no bubbles at wrap-around.
- Full: count > DEPTH − IN_WIDTH ⇒ in_ready=0 from the following cycle. A pop in that cycle reopens in_ready one cycle later.
- Empty: count=0 ⇒ out_valid=0 (without bypass).
- Mid-operation reset or flush: contents are gone the next cycle. A push in the same cycle as flush is never presented.

## Configuration
- INST_BUF_BYPASS_EN defined: when count=0 and flush=0, input slots drive output slots directly in the same cycle.
  - out_valid[i] = in_valid[i] && in_ready, for i < OUT_WIDTH.
  - The first out_take input slots are consumed; only the remaining valid slots are written, starting at tail.
  - Latency 0 when empty. When count>0, normal buffered behaviour applies.
- INST_BUF_BYPASS_EN undefined: no combinational in→out path; latency is always 1.

## Structure
- `cpu_config.svh` holds defaults: `InstBufDepth`, `FetchWidth`, `DecodeWidth`.
- Package `inst_buf_pkg` holds typedef InstBufEnt_t {pc, inst, pred}, parametrised via ADDR/INST macros.
- Sub-module `inst_buf_ptr`: a modulo-DEPTH pointer that advances by a variable amount (0..max(IN_WIDTH, OUT_WIDTH)). It is instantiated for head and tail.

## Test plan
All scenarios use the defaults (DEPTH=8, IN_WIDTH=2, OUT_WIDTH=2).
- Reset, then push {pc 0x100, 0x104} with in_valid=2'b11 → next cycle count=2, out_valid=2'b11, out_pc slot0=0x100, slot1=0x104.
- Push 2 per cycle with out_take=0 for 4 cycles → count=8, in_ready=0 after count reaches 8 (in_ready falls once count > 6). A fifth push attempt is ignored and count stays 8.
- Steady state: push 2 and take 2 every cycle for 10 cycles → count constant. PCs come out in order across head/tail wrap (0x100…0x14c).
- Partial: in_valid=2'b01 with pc 0x200 while count=3, out_take=1 → count stays 3. 0x200 appears at slot position 2 relative to the new head.
- Flush while count=5 with a concurrent push → next cycle count=0, out_valid=0. The pushed PC never appears.
- With INST_BUF_BYPASS_EN: empty buffer, push {0x300, 0x304}, out_take=1 → same-cycle out_pc slot0=0x300. Next cycle count=1 with 0x304 at slot0.
